// File: rtl/rapcla_pkg.sv
// rtl/rapcla_pkg.sv - shared types and constants for the variable-latency approximate CLA pipe
package rapcla_pkg;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_OUT} state_t;

  localparam int ERRCNT_W = 16;

  function automatic int ngroups(input int size, input int groupsize);
    return size / groupsize;
  endfunction
endpackage

// File: rtl/rapcla_group_core.sv
// rtl/rapcla_group_core.sv - one combinational CLA group with a windowed approximate carry-out
module rapcla_group_core #(
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 4
) (
  input  logic [GROUPSIZE-1:0] i_a,
  input  logic [GROUPSIZE-1:0] i_b,
  input  logic                 i_cin,
  input  logic                 i_approx,
  output logic [GROUPSIZE-1:0] o_sum,
  output logic                 o_cout,
  output logic                 o_cout_exact,
  output logic                 o_err
);
  localparam int LW = GROUPSIZE - WINDOW;

  logic [GROUPSIZE-1:0] w_p, w_g;
  logic [GROUPSIZE:0]   w_c;
  logic                 w_gu, w_pu, w_cb;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    for (int k = 0; k < GROUPSIZE; k++) w_c[k+1] = w_g[k] | (w_p[k] & w_c[k]);
  end

  // Upper-window generate evaluated with zero carry-in: the approximate carry ignores c_b
  always_comb begin
    w_gu = 1'b0;
    for (int k = LW; k < GROUPSIZE; k++) w_gu = w_g[k] | (w_p[k] & w_gu);
  end

  assign w_pu         = &w_p[GROUPSIZE-1:LW];
  assign w_cb         = w_c[LW];
  assign o_sum        = w_p ^ w_c[GROUPSIZE-1:0];
  assign o_cout_exact = w_c[GROUPSIZE];
  assign o_cout       = i_approx ? w_gu : w_c[GROUPSIZE];
  assign o_err        = i_approx & w_pu & w_cb;
endmodule

// File: rtl/rapcla_vl_pipe.sv
// rtl/rapcla_vl_pipe.sv - handshaked approximate CLA with optional exact-correction cycle
// Optional error statistics counter enabled by RAPCLA_ERRSTAT_EN.
module rapcla_vl_pipe
  import rapcla_pkg::*;
#(
  parameter int SIZE      = 32,
  parameter int GROUPSIZE = 8,
  parameter int WINDOW    = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [SIZE:1]            A,
  input  logic [SIZE:1]            B,
  input  logic                     CIN,
  input  logic [SIZE/GROUPSIZE:1]  APPROX_RCON,
  input  logic                     CORRECT_REQ,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [SIZE:1]            SUM,
  output logic                     COUT,
  output logic [SIZE/GROUPSIZE:1]  ERR_GRP,
  output logic                     EXACT
`ifdef RAPCLA_ERRSTAT_EN
  ,
  input  logic                     ERR_CLR,
  output logic [ERRCNT_W-1:0]      ERR_CNT
`endif
);
  localparam int NG = ngroups(SIZE, GROUPSIZE);

  state_t        r_state, w_next;
  logic [SIZE:1] r_a, r_b;
  logic          r_cin, r_corr;
  logic [NG:1]   r_rcon;
  logic [SIZE:1] r_sum;
  logic          r_cout, r_exact;
  logic [NG:1]   r_err;

  logic          w_ac [0:NG];
  logic          w_ec [0:NG];
  logic [SIZE:1] w_asum, w_esum;
  logic [NG:1]   w_aerr, w_eerr, w_acx, w_ecx;
  logic          w_accept, w_mismatch, w_load_apx, w_load_exact, w_unused;

  assign w_ac[0] = r_cin;
  assign w_ec[0] = r_cin;

  for (genvar gi = 1; gi <= NG; gi++) begin : g_grp
    rapcla_group_core #(.GROUPSIZE(GROUPSIZE), .WINDOW(WINDOW)) u_apx (
      .i_a(r_a[gi*GROUPSIZE -: GROUPSIZE]), .i_b(r_b[gi*GROUPSIZE -: GROUPSIZE]),
      .i_cin(w_ac[gi-1]), .i_approx(r_rcon[gi]),
      .o_sum(w_asum[gi*GROUPSIZE -: GROUPSIZE]), .o_cout(w_ac[gi]),
      .o_cout_exact(w_acx[gi]), .o_err(w_aerr[gi])
    );
    rapcla_group_core #(.GROUPSIZE(GROUPSIZE), .WINDOW(WINDOW)) u_ext (
      .i_a(r_a[gi*GROUPSIZE -: GROUPSIZE]), .i_b(r_b[gi*GROUPSIZE -: GROUPSIZE]),
      .i_cin(w_ec[gi-1]), .i_approx(1'b0),
      .o_sum(w_esum[gi*GROUPSIZE -: GROUPSIZE]), .o_cout(w_ec[gi]),
      .o_cout_exact(w_ecx[gi]), .o_err(w_eerr[gi])
    );
  end

  assign w_unused   = ^{w_eerr, w_acx, w_ecx};
  assign w_mismatch = {w_ac[NG], w_asum} != {w_ec[NG], w_esum};
  assign IN_READY   = (r_state == S_IDLE) | ((r_state == S_OUT) & OUT_READY);
  assign w_accept   = IN_VALID & IN_READY;
  assign OUT_VALID  = (r_state == S_OUT);
  assign SUM        = r_sum;
  assign COUT       = r_cout;
  assign ERR_GRP    = r_err;
  assign EXACT      = r_exact;

  always_comb begin
    w_next       = r_state;
    w_load_apx   = 1'b0;
    w_load_exact = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_CALC;
      S_CALC: begin
        if (r_corr && w_mismatch) w_next = S_FIX;
        else begin
          w_load_apx = 1'b1;
          w_next     = S_OUT;
        end
      end
      S_FIX: begin
        w_load_exact = 1'b1;
        w_next       = S_OUT;
      end
      S_OUT: if (OUT_READY) w_next = w_accept ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Operands stay frozen through CALC/FIX since IN_READY is low there
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a <= '0; r_b <= '0; r_cin <= 1'b0; r_rcon <= '0; r_corr <= 1'b0;
      r_sum <= '0; r_cout <= 1'b0; r_err <= '0; r_exact <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a <= A; r_b <= B; r_cin <= CIN; r_rcon <= APPROX_RCON; r_corr <= CORRECT_REQ;
      end
      if (r_state == S_CALC) r_err <= w_aerr;
      if (w_load_apx) begin
        r_sum <= w_asum; r_cout <= w_ac[NG]; r_exact <= !w_mismatch;
      end
      if (w_load_exact) begin
        r_sum <= w_esum; r_cout <= w_ec[NG]; r_exact <= 1'b1;
      end
    end
  end

`ifdef RAPCLA_ERRSTAT_EN
  logic [ERRCNT_W-1:0] r_err_cnt;

  always_ff @(posedge CLK) begin
    if (RST || ERR_CLR) r_err_cnt <= '0;
    else if ((r_state == S_CALC) && w_mismatch && (r_err_cnt != {ERRCNT_W{1'b1}}))
      r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign ERR_CNT = r_err_cnt;
`endif
endmodule

// File: tb/tb_rapcla_vl_pipe.sv
// tb/tb_rapcla_vl_pipe.sv - directed vector bench for rapcla_vl_pipe
module tb_rapcla_vl_pipe;
  localparam int SIZE = 16;
  localparam int GS   = 8;
  localparam int WIN  = 4;
  localparam int NG   = 2;

  logic          CLK = 1'b0;
  logic          RST, IN_VALID, IN_READY, CIN, CORRECT_REQ;
  logic          OUT_VALID, OUT_READY, COUT, EXACT;
  logic [SIZE:1] A, B, SUM;
  logic [NG:1]   APPROX_RCON, ERR_GRP;
`ifdef RAPCLA_ERRSTAT_EN
  logic [15:0]   ERR_CNT;
  logic          ERR_CLR;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  rapcla_vl_pipe #(.SIZE(SIZE), .GROUPSIZE(GS), .WINDOW(WIN)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .CIN(CIN), .APPROX_RCON(APPROX_RCON), .CORRECT_REQ(CORRECT_REQ),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .SUM(SUM), .COUT(COUT),
    .ERR_GRP(ERR_GRP), .EXACT(EXACT)
`ifdef RAPCLA_ERRSTAT_EN
    , .ERR_CLR(ERR_CLR), .ERR_CNT(ERR_CNT)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [1:0]  rcon;
    logic        corr;
    logic [15:0] sum;
    logic        cout;
    logic [1:0]  err;
    logic        exact;
    int          lat;
  } vec_t;

  vec_t vecs [12];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    A = v.a; B = v.b; CIN = v.cin; APPROX_RCON = v.rcon; CORRECT_REQ = v.corr;
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    int guard;
    int lat;
    guard = 0;
    while (!IN_READY && guard < 10) begin
      step();
      guard++;
    end
    chk($sformatf("v%0d_in_ready", idx), IN_READY, 1);
    drive(v);
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 10) begin
      step();
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_sum", idx), SUM, v.sum);
    chk($sformatf("v%0d_cout", idx), COUT, v.cout);
    chk($sformatf("v%0d_err_grp", idx), ERR_GRP, v.err);
    chk($sformatf("v%0d_exact", idx), EXACT, v.exact);
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    chk($sformatf("v%0d_valid_drop", idx), OUT_VALID, 0);
  endtask

  initial begin
    //           a        b        cin   rcon   corr  sum      cout  err    exact lat
    vecs[0]  = '{16'h1234, 16'h0101, 1'b0, 2'b11, 1'b1, 16'h1335, 1'b0, 2'b00, 1'b1, 2};
    vecs[1]  = '{16'h00FF, 16'h0001, 1'b0, 2'b01, 1'b0, 16'h0000, 1'b0, 2'b01, 1'b0, 2};
    vecs[2]  = '{16'h00FF, 16'h0001, 1'b0, 2'b01, 1'b1, 16'h0100, 1'b0, 2'b01, 1'b1, 3};
    vecs[3]  = '{16'hFFFF, 16'h0000, 1'b1, 2'b00, 1'b1, 16'h0000, 1'b1, 2'b00, 1'b1, 2};
    vecs[4]  = '{16'hFFFF, 16'h0000, 1'b1, 2'b10, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b0, 2};
    vecs[5]  = '{16'hFFFF, 16'h0000, 1'b1, 2'b10, 1'b1, 16'h0000, 1'b1, 2'b10, 1'b1, 3};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 2'b00, 1'b0, 16'h0000, 1'b1, 2'b00, 1'b1, 2};
    vecs[7]  = '{16'h0FF0, 16'h0010, 1'b0, 2'b01, 1'b0, 16'h1000, 1'b0, 2'b00, 1'b1, 2};
    vecs[8]  = '{16'h0018, 16'h0008, 1'b0, 2'b11, 1'b0, 16'h0020, 1'b0, 2'b00, 1'b1, 2};
    vecs[9]  = '{16'hABCD, 16'h1234, 1'b1, 2'b00, 1'b0, 16'hBE02, 1'b0, 2'b00, 1'b1, 2};
    vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b1, 2'b11, 1'b0, 16'hFFFF, 1'b1, 2'b00, 1'b1, 2};
    vecs[11] = '{16'hFF00, 16'h0100, 1'b0, 2'b10, 1'b0, 16'h0000, 1'b0, 2'b10, 1'b0, 2};

    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
    A = '0; B = '0; CIN = 1'b0; APPROX_RCON = '0; CORRECT_REQ = 1'b0;
`ifdef RAPCLA_ERRSTAT_EN
    ERR_CLR = 1'b0;
`endif
    step();
    step();
    RST = 1'b0;
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_in_ready", IN_READY, 1);
    chk("rst_sum", SUM, 0);
    chk("rst_cout", COUT, 0);
    chk("rst_err_grp", ERR_GRP, 0);
    chk("rst_exact", EXACT, 0);
`ifdef RAPCLA_ERRSTAT_EN
    chk("rst_err_cnt", ERR_CNT, 0);
`endif

    for (int i = 0; i < 12; i++) do_txn(vecs[i], i);

    // Backpressure: hold result for 5 cycles, then release with a back-to-back accept
    drive(vecs[0]);
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    chk("bp_out_valid", OUT_VALID, 1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d_sum", c), SUM, 16'h1335);
      chk($sformatf("bp_hold%0d_in_ready", c), IN_READY, 0);
      chk($sformatf("bp_hold%0d_valid", c), OUT_VALID, 1);
      step();
    end
    drive(vecs[9]);
    IN_VALID = 1'b1;
    OUT_READY = 1'b1;
    #1;
    chk("bp_release_in_ready", IN_READY, 1);
    step();
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
    chk("bp_calc_valid", OUT_VALID, 0);
    chk("bp_calc_in_ready", IN_READY, 0);
    step();
    chk("bp_next_valid", OUT_VALID, 1);
    chk("bp_next_sum", SUM, 16'hBE02);
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;

    // Reset while in the correction cycle
    drive(vecs[2]);
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    chk("fix_out_valid", OUT_VALID, 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("fixrst_out_valid", OUT_VALID, 0);
    chk("fixrst_in_ready", IN_READY, 1);
    chk("fixrst_sum", SUM, 0);
    chk("fixrst_err_grp", ERR_GRP, 0);
    step();
    step();
    chk("fixrst_still_idle", OUT_VALID, 0);

`ifdef RAPCLA_ERRSTAT_EN
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("errcnt_clr0", ERR_CNT, 0);
    for (int i = 0; i < 3; i++) do_txn(vecs[1], 100 + i);
    chk("errcnt_three", ERR_CNT, 3);
    do_txn(vecs[0], 200);
    chk("errcnt_clean_txn", ERR_CNT, 3);
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("errcnt_clr", ERR_CNT, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rapcla_vl_pipe.md
Name: rapcla_vl_pipe

Overview:
- Registered, handshaked, variable-latency successor to the combinational reconfigurable approximate CLA.
- Each group's carry-out is taken from the upper window only when its approximation bit is set.
- Per-group error detection compares against exact carry-out.
- When correction is requested, one extra cycle is spent to emit the exact result.
- Sits between operand producers and accumulate/datapath stages needing selectable accuracy/latency.

Parameters:
- SIZE, 32, adder width in bits; must be a multiple of GROUPSIZE.
- GROUPSIZE, 8, bits per group.
- WINDOW, 4, upper-subgroup carry window; 1 <= WINDOW < GROUPSIZE.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  operand valid.
- IN_READY  out  1  block accepts operands this cycle.
- A  in  SIZE  operand A; bit 1 is the LSB, indexed [SIZE:1].
- B  in  SIZE  operand B, indexed [SIZE:1].
- CIN  in  1  carry-in.
- APPROX_RCON  in  SIZE/GROUPSIZE  per-group mode, 1 = approximate, 0 = exact; bit 1 is the lowest group.
- CORRECT_REQ  in  1  per transaction: replace an erroneous approximate result by the exact one.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  consumer accepts result.
- SUM  out  SIZE  result, indexed [SIZE:1].
- COUT  out  1  result carry-out.
- ERR_GRP  out  SIZE/GROUPSIZE  groups whose approximate carry-out was wrong.
- EXACT  out  1  SUM/COUT equal the exact A+B+CIN.

Behaviour:
- Clocking and reset: single clock CLK; RST is synchronous, active-high.
- Reset values: state=S_IDLE, OUT_VALID=0, SUM=0, COUT=0, ERR_GRP=0, EXACT=0. IN_READY=1 in the first cycle after reset.
- Approximate carry chain (combinational, per group i):
  - Lower subgroup (GROUPSIZE-WINDOW bits) ripples from the carry into group i, giving boundary carry c_b[i].
  - Upper subgroup ripples from c_b[i].
  - Approximate group carry-out = G_upper[i] when APPROX_RCON[i]=1; otherwise G_upper[i] | (P_upper[i] & c_b[i]).
  - Group i+1 consumes the approximate carry-out.
  - SUM[k] = p[k] ^ carry[k-1].
- Exact chain: identical structure with every group exact.
- Error flags:
  - ERR_GRP[i] = APPROX_RCON[i] & P_upper[i] & c_b[i], evaluated on the approximate chain.
  - mismatch = (approx {COUT,SUM} != exact {COUT,SUM}).
- Accept: IN_VALID & IN_READY. Capture A, B, CIN, APPROX_RCON, CORRECT_REQ into the input register; compute both chains from that register.
- FSM:
  - S_IDLE: on accept -> S_CALC.
  - S_CALC: one cycle.
    - If CORRECT_REQ_q & mismatch -> S_FIX.
    - Otherwise load the approximate result with EXACT=!mismatch -> S_OUT.
  - S_FIX: load the exact result, EXACT=1, ERR_GRP keeps its detected value -> S_OUT.
  - S_OUT: OUT_VALID=1; outputs held stable until OUT_READY.
    - On OUT_READY & accept -> S_CALC (back-to-back).
    - On OUT_READY with no accept -> S_IDLE.
    - Otherwise stay in S_OUT.
- IN_READY = (state==S_IDLE) | (state==S_OUT & OUT_READY). Combinational from OUT_READY, deasserted in S_CALC and S_FIX.
- Latency from accept to OUT_VALID: 2 cycles without correction, 3 with correction. Throughput: 1 result per 2 cycles.
- All APPROX_RCON=0: mismatch is always 0, EXACT=1, no correction cycle.
- An approximation bit on the top group affects only COUT.
- RST mid-transaction: the transaction is discarded; a held result is dropped with no OUT_VALID.
- CORRECT_REQ=0 with mismatch: the approximate result is output with EXACT=0.

Optional Feature:
- Macro: RAPCLA_ERRSTAT_EN.
- Defined:
  - Adds output ERR_CNT[15:0], a saturating count of transactions with mismatch=1 (counted once at S_CALC), cleared by RST.
  - Adds input ERR_CLR, a synchronous clear with priority over increment.
  - Counter holds at 0xFFFF.
- Undefined: neither port nor logic exists; behaviour otherwise identical.

Decomposition:
- Package rapcla_pkg:
  - state enum {S_IDLE, S_CALC, S_FIX, S_OUT}.
  - function ngroups(SIZE, GROUPSIZE).
  - ERRCNT_W=16 constant.
- Sub-module rapcla_group_core: one combinational group instance.
  - Inputs: A/B slice, carry-in, approx bit.
  - Outputs: sum slice, approximate carry-out, exact carry-out, err bit.
  - Instantiated twice per group (approximate chain and exact chain with approx tied 0).

Test Plan (SIZE=16, GROUPSIZE=8, WINDOW=4):
- A=0x1234, B=0x0101, CIN=0, RCON=2'b11, CORRECT_REQ=1 -> 2 cycles; SUM=0x1335, COUT=0, ERR_GRP=00, EXACT=1.
- A=0x00FF, B=0x0001, CIN=0, RCON=2'b01, CORRECT_REQ=0 -> 2 cycles; SUM=0x0000, COUT=0, ERR_GRP=01, EXACT=0.
- Same operands with CORRECT_REQ=1 -> OUT_VALID after 3 cycles; SUM=0x0100, COUT=0, ERR_GRP=01, EXACT=1.
- A=0xFFFF, B=0x0000, CIN=1, RCON=2'b00 -> SUM=0x0000, COUT=1, EXACT=1; repeat with RCON=2'b10 -> COUT=0, ERR_GRP=10, EXACT=0.
- Backpressure: OUT_READY=0 for 5 cycles -> outputs stable, IN_READY=0; then OUT_READY=1 with IN_VALID=1 -> next operand accepted in the same cycle.
- RST asserted during S_FIX -> next cycle OUT_VALID=0, IN_READY=1, SUM=0. With RAPCLA_ERRSTAT_EN: 3 erroneous transactions -> ERR_CNT=3; ERR_CLR -> 0.
